// File: rtl/reg_file_2w2r_if.sv
// Bus bundle for reg_file_2w2r: two write ports, two read ports,
// flat register view and sticky address error.
interface reg_file_2w2r_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) ();
  logic                       wa_en;
  logic [ADDR_W-1:0]          wa_addr;
  logic [DATA_W-1:0]          wa_data;
  logic                       wb_en;
  logic [ADDR_W-1:0]          wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic [ADDR_W-1:0]          ra_addr;
  logic [ADDR_W-1:0]          rb_addr;
  logic [DATA_W-1:0]          ra_data;
  logic [DATA_W-1:0]          rb_data;
  logic [NUM_REGS*DATA_W-1:0] all_out;
  logic                       clr_err;
  logic                       addr_err;

  modport master (
    output wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output ra_addr, rb_addr, clr_err,
    input  ra_data, rb_data, all_out, addr_err
  );

  modport slave (
    input  wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  ra_addr, rb_addr, clr_err,
    output ra_data, rb_data, all_out, addr_err
  );
endinterface

// File: rtl/reg_file_2w2r.sv
// 2-write / 2-registered-read register file with sticky range error.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes to the reads.
module reg_file_2w2r #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input logic            clock,
  input logic            reset,
  reg_file_2w2r_if.slave bus
);

  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] src    [NUM_REGS];
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              err_q, err_d;
  logic              wa_in, wb_in;
  logic              ra_in, rb_in;
  logic              wa_wr, wb_wr;
  logic              err_set;

  assign wa_in = {1'b0, bus.wa_addr} < NREGS;
  assign wb_in = {1'b0, bus.wb_addr} < NREGS;
  assign ra_in = {1'b0, bus.ra_addr} < NREGS;
  assign rb_in = {1'b0, bus.rb_addr} < NREGS;

  assign wa_wr = bus.wa_en && wa_in &&
                 !(ZERO_REG != 0 && bus.wa_addr == '0);
  assign wb_wr = bus.wb_en && wb_in &&
                 !(ZERO_REG != 0 && bus.wb_addr == '0);

  // port B is applied last so it wins an address collision
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wa_wr && bus.wa_addr == ADDR_W'(i))
        regs_d[i] = bus.wa_data;
      if (wb_wr && bus.wb_addr == ADDR_W'(i))
        regs_d[i] = bus.wb_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REG_FILE_BYPASS_EN
      src[i] = regs_d[i];
`else
      src[i] = regs_q[i];
`endif
    end
  end

  always_comb begin
    ra_d = '0;
    rb_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.ra_addr == ADDR_W'(i))
        ra_d = src[i];
      if (bus.rb_addr == ADDR_W'(i))
        rb_d = src[i];
    end
    if (ZERO_REG != 0 && bus.ra_addr == '0)
      ra_d = '0;
    if (ZERO_REG != 0 && bus.rb_addr == '0)
      rb_d = '0;
  end

  assign err_set = (bus.wa_en && !wa_in) ||
                   (bus.wb_en && !wb_in) ||
                   !ra_in || !rb_in;
  assign err_d   = err_set || (err_q && !bus.clr_err);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= regs_d[i];
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      err_q <= err_d;
    end
  end

  // reg 0 occupies the most significant slice
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.all_out[DATA_W*(NUM_REGS-1-g) +: DATA_W] = regs_q[g];
  end

  assign bus.ra_data  = ra_q;
  assign bus.rb_data  = rb_q;
  assign bus.addr_err = err_q;

endmodule
